// File: rtl/lfsr_stream_crypt_if.sv
// Bus of lfsr_stream_crypt: run control (req/ack/mode), key config,
// input byte stream (in_*), output byte stream (out_*), discovery status.
//   master : controller / stream source and sink (drives req, cfg, in_*, out_ready)
//   slave  : lfsr_stream_crypt
interface lfsr_stream_crypt_if #(
  parameter int LFSR_W   = 7,
  parameter int NUM_PTRN = 9
);
  localparam int IDX_W = $clog2(NUM_PTRN);

  logic              req;
  logic              ack;
  logic [1:0]        mode;
  logic [LFSR_W-1:0] cfg_taps;
  logic [LFSR_W-1:0] cfg_seed;
  logic              in_valid;
  logic [LFSR_W:0]   in_data;
  logic              in_ready;
  logic              out_valid;
  logic [LFSR_W:0]   out_data;
  logic              out_ready;
  logic              err;
  logic [IDX_W-1:0]  found_idx;

  modport master (
    output req, mode, cfg_taps, cfg_seed, in_valid, in_data, out_ready,
    input  ack, in_ready, out_valid, out_data, err, found_idx
  );

  modport slave (
    input  req, mode, cfg_taps, cfg_seed, in_valid, in_data, out_ready,
    output ack, in_ready, out_valid, out_data, err, found_idx
  );
endinterface

// File: rtl/lfsr_stream_crypt.sv
// LFSR stream cipher with optional tap-pattern discovery.
//   clk  : rising-edge clock
//   init : synchronous active-high reset, wins over req
//   bus  : lfsr_stream_crypt_if.slave (req/ack, mode, cfg_taps/cfg_seed,
//          in_* and out_* valid/ready byte streams, err, found_idx)
// Each run consumes LEN bytes and emits exactly LEN bytes. Bytes are LFSR_W
// data bits plus an MSB parity bit (even parity over the whole byte).
// Mode 0 encrypts, mode 1/3 decrypts with the given key, mode 2 recovers the
// key from the known PAD prefix, then decrypts. Leading pads are stripped on
// decrypt and the tail is refilled with PAD.

// One candidate tap pattern: does stepping prev with these taps yield obs?
module lfsr_ptrn_chk #(
  parameter int LFSR_W = 7
) (
  input  logic [LFSR_W-1:0] taps,
  input  logic [LFSR_W-1:0] prev,
  input  logic [LFSR_W-1:0] obs,
  output logic              hit
);
  assign hit = ({prev[LFSR_W-2:0], ^(prev & taps)} == obs);
endmodule

module lfsr_stream_crypt #(
  parameter int                         LFSR_W     = 7,
  parameter int                         LEN        = 64,
  parameter int                         MIN_PRE    = 10,
  parameter logic [LFSR_W-1:0]          PAD        = 7'h20,
  parameter int                         NUM_PTRN   = 9,
  parameter logic [NUM_PTRN*LFSR_W-1:0] PTRN_TABLE =
    {7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60}
) (
  input  logic               clk,
  input  logic               init,
  lfsr_stream_crypt_if.slave bus
);
  localparam int CNT_W = $clog2(LEN + 1);
  localparam int IDX_W = $clog2(NUM_PTRN);
  localparam int PC_W  = $clog2(NUM_PTRN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DISCOVER, S_STRIP, S_PASS, S_FILL, S_DONE
  } state_t;

  state_t              state;
  logic [1:0]          mode_q;
  logic [LFSR_W-1:0]   taps_q;
  logic [LFSR_W-1:0]   lfsr;
  logic [CNT_W-1:0]    in_cnt;
  logic [CNT_W-1:0]    out_cnt;
  logic [NUM_PTRN-1:0] live;
  logic                lead;      // mode 1/3: still dropping leading pads in PASS
  logic                ack_q;
  logic                err_q;
  logic [IDX_W-1:0]    found_q;
  logic                out_valid_q;
  logic [LFSR_W:0]     out_data_q;

  logic [NUM_PTRN-1:0][LFSR_W-1:0] ptrn;
  assign ptrn = PTRN_TABLE;

  // Data path for the byte currently offered on the input.
  logic [LFSR_W-1:0] xored, obs, found_taps, disc_nxt, lfsr_nxt;
  logic [LFSR_W:0]   proc_byte;
  logic              perr, drop, out_free, consuming, acc;

  assign xored    = bus.in_data[LFSR_W-1:0] ^ lfsr;
  assign obs      = bus.in_data[LFSR_W-1:0] ^ PAD;   // keystream while the prefix is pad
  assign perr     = ^bus.in_data;
  assign lfsr_nxt = {lfsr[LFSR_W-2:0], ^(lfsr & taps_q)};
  assign proc_byte = (mode_q == 2'd0) ? {^xored, xored} : {perr, xored};
  assign drop     = ((state == S_STRIP) || (state == S_PASS && lead)) &&
                    (xored == PAD) && !perr;

  assign out_free  = !out_valid_q || bus.out_ready;
  assign consuming = (state == S_DISCOVER) || (state == S_STRIP) || (state == S_PASS);
  assign acc       = bus.in_valid && bus.in_ready;

  // Candidate elimination: each checker tests obs against the previous state.
  logic [NUM_PTRN-1:0] hit, live_nxt;
  logic [PC_W-1:0]     live_cnt;
  logic [IDX_W-1:0]    live_idx;

  for (genvar j = 0; j < NUM_PTRN; j++) begin : g_chk
    lfsr_ptrn_chk #(.LFSR_W(LFSR_W)) u_chk (
      .taps (ptrn[j]),
      .prev (lfsr),
      .obs  (obs),
      .hit  (hit[j])
    );
  end

  // Byte 0 only seeds the state; nothing to compare against yet.
  assign live_nxt = (in_cnt == '0) ? '1 : (live & hit);

  always_comb begin
    live_cnt = '0;
    live_idx = '0;
    for (int j = 0; j < NUM_PTRN; j++) begin
      if (live_nxt[j]) begin
        live_cnt = live_cnt + PC_W'(1);
        live_idx = IDX_W'(j);
      end
    end
  end

  assign found_taps = ptrn[live_idx];
  // State for the first byte after discovery, stepped from the last prefix byte.
  assign disc_nxt   = {obs[LFSR_W-2:0], ^(obs & found_taps)};

  assign bus.in_ready  = consuming && (in_cnt < CNT_W'(LEN)) && out_free;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.ack       = ack_q;
  assign bus.err       = err_q;
  assign bus.found_idx = found_q;

  always_ff @(posedge clk) begin
    if (init) begin
      state       <= S_IDLE;
      mode_q      <= '0;
      taps_q      <= '0;
      lfsr        <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      live        <= '0;
      lead        <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      found_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      // Drain by default; a load below takes precedence.
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (bus.req) begin
            mode_q  <= bus.mode;
            taps_q  <= bus.cfg_taps;
            lfsr    <= bus.cfg_seed;
            in_cnt  <= '0;
            out_cnt <= '0;
            live    <= '1;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            lead    <= (bus.mode == 2'd1) || (bus.mode == 2'd3);
            state   <= (bus.mode == 2'd2) ? S_DISCOVER : S_PASS;
          end
        end

        S_DISCOVER: begin
          if (acc) begin
            in_cnt <= in_cnt + CNT_W'(1);
            lfsr   <= obs;
            live   <= live_nxt;
            if (perr) begin
              err_q <= 1'b1;
              ack_q <= 1'b1;
              state <= S_DONE;
            end else if (in_cnt == CNT_W'(MIN_PRE - 1)) begin
              if (live_cnt == PC_W'(1)) begin
                found_q <= live_idx;
                taps_q  <= found_taps;
                lfsr    <= disc_nxt;
                state   <= S_STRIP;
              end else begin
                err_q <= 1'b1;
                ack_q <= 1'b1;
                state <= S_DONE;
              end
            end
          end
        end

        S_STRIP, S_PASS: begin
          if (in_cnt == CNT_W'(LEN)) begin
            state <= S_FILL;
          end else if (acc) begin
            in_cnt <= in_cnt + CNT_W'(1);
            lfsr   <= lfsr_nxt;
            if (!drop) begin
              out_valid_q <= 1'b1;
              out_data_q  <= proc_byte;
              out_cnt     <= out_cnt + CNT_W'(1);
              lead        <= 1'b0;
              state       <= S_PASS;
            end
          end
        end

        S_FILL: begin
          if (out_cnt == CNT_W'(LEN)) begin
            ack_q <= 1'b1;
            state <= S_DONE;
          end else if (out_free) begin
            out_valid_q <= 1'b1;
            out_data_q  <= {1'b0, PAD};
            out_cnt     <= out_cnt + CNT_W'(1);
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lfsr_stream_crypt.sv
module tb_lfsr_stream_crypt;
  localparam int LFSR_W = 7, LEN = 64, MIN_PRE = 10, NUM_PTRN = 9;
  localparam logic [6:0] PAD = 7'h20;

  logic clk = 1'b0;
  logic init = 1'b1;

  lfsr_stream_crypt_if #(.LFSR_W(LFSR_W), .NUM_PTRN(NUM_PTRN)) bus ();

  lfsr_stream_crypt #(
    .LFSR_W(LFSR_W), .LEN(LEN), .MIN_PRE(MIN_PRE), .PAD(PAD), .NUM_PTRN(NUM_PTRN)
  ) dut (
    .clk  (clk),
    .init (init),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [7:0] stim[$], exp_q[$], rx_q[$], plain[$];
  logic [6:0] cand[NUM_PTRN] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
  bit m_err;
  int m_idx, exp_len;
  bit aborted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] nxt(input logic [6:0] s, input logic [6:0] t);
    return 7'(s << 1) | 7'($countones(s & t) % 2);
  endfunction

  function automatic bit odd(input logic [7:0] b);
    return ($countones(b) % 2) == 1;
  endfunction

  task automatic encrypt_plain(input logic [6:0] t, input logic [6:0] seed);
    logic [6:0] s, c;
    s = seed;
    stim.delete();
    foreach (plain[k]) begin
      c = plain[k][6:0] ^ s;
      stim.push_back({odd({1'b0, c}), c});
      s = nxt(s, t);
    end
  endtask

  task automatic build_expected(input logic [1:0] m, input logic [6:0] t0, input logic [6:0] seed);
    logic [6:0] s, t, p;
    logic [6:0] obs[MIN_PRE];
    bit perr, strip, ok;
    int k, nlive;
    exp_q.delete();
    m_err = 0; m_idx = 0; s = seed; t = t0; k = 0; strip = (m != 2'd0);
    if (m == 2'd2) begin
      for (int i = 0; i < MIN_PRE; i++) begin
        if (odd(stim[i])) m_err = 1;
        obs[i] = stim[i][6:0] ^ PAD;
      end
      nlive = 0;
      for (int j = 0; j < NUM_PTRN; j++) begin
        ok = 1;
        for (int i = 1; i < MIN_PRE; i++) if (nxt(obs[i-1], cand[j]) != obs[i]) ok = 0;
        if (ok) begin nlive++; m_idx = j; end
      end
      if (nlive != 1) m_err = 1;
      if (!m_err) begin
        t = cand[m_idx];
        s = nxt(obs[MIN_PRE-1], t);
        k = MIN_PRE;
      end
    end
    if (!m_err) begin
      for (; k < LEN; k++) begin
        p = stim[k][6:0] ^ s;
        perr = odd(stim[k]);
        if (!(strip && p == PAD && !perr)) begin
          strip = 0;
          exp_q.push_back((m == 2'd0) ? {odd({1'b0, p}), p} : {perr, p});
        end
        s = nxt(s, t);
      end
      while (exp_q.size() < LEN) exp_q.push_back({1'b0, PAD});
    end
    exp_len = exp_q.size();
  endtask

  // ---------------- output compare process ----------------
  logic [7:0] held;
  bit holding = 0;
  always @(negedge clk) begin
    if (holding && bus.out_valid && !init) chk("out_hold", bus.out_data, held);
    if (bus.out_valid && bus.out_ready) begin
      rx_q.push_back(bus.out_data);
      chk("out_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("out_data", bus.out_data, exp_q.pop_front());
    end
    holding = bus.out_valid && !bus.out_ready;
    held    = bus.out_data;
  end

  // ---------------- stimulus tasks ----------------
  task automatic start_run(input logic [1:0] m, input logic [6:0] t, input logic [6:0] seed);
    @(posedge clk); #1;
    rx_q.delete();
    bus.mode = m; bus.cfg_taps = t; bus.cfg_seed = seed; bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
  endtask

  task automatic drive(input int abort_at);
    int i, guard;
    i = 0; guard = 0; aborted = 0;
    while (i < stim.size() && guard < 3000) begin
      if (i == abort_at) begin
        bus.in_valid = 1'b0;
        init = 1'b1;
        @(posedge clk); #1;
        init = 1'b0;
        aborted = 1;
        break;
      end
      bus.in_valid = 1'b1;
      bus.in_data  = stim[i];
      @(negedge clk);
      if (bus.ack) break;
      if (bus.in_ready) i++;
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b0;
    if (!aborted && !bus.ack) chk("drive_consumed", i, stim.size());
  endtask

  task automatic stall_at(input int nbytes);
    int g;
    g = 0;
    while (rx_q.size() < nbytes && g < 1000) begin @(posedge clk); #1; g++; end
    bus.out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!bus.ack && cyc < 1000);
    chk({tag, "_ack"}, bus.ack, 1);
    repeat (3) @(negedge clk);
    chk({tag, "_err"}, bus.err, m_err);
    chk({tag, "_rx_count"}, rx_q.size(), exp_len);
    chk({tag, "_exp_left"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, bus.ack, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_found_idx"}, bus.found_idx, 0);
  endtask

  task automatic fill_random;
    stim.delete();
    for (int i = 0; i < LEN; i++) stim.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic set_plain(input string txt, input int pre);
    plain.delete();
    for (int i = 0; i < pre; i++) plain.push_back({1'b0, PAD});
    for (int i = 0; i < txt.len(); i++) plain.push_back(txt[i]);
    while (plain.size() < LEN) plain.push_back({1'b0, PAD});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] seed;
    bus.req = 0; bus.mode = 0; bus.cfg_taps = 0; bus.cfg_seed = 0;
    bus.in_valid = 0; bus.in_data = 0; bus.out_ready = 1;

    repeat (3) @(posedge clk); #1;
    init = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // Encrypt, taps 0x60 seed 0x01: 0x41,0x41 -> 0xC0,0xC3
    stim.delete();
    for (int i = 0; i < LEN; i++) stim.push_back(8'h41);
    build_expected(2'd0, 7'h60, 7'h01);
    chk("model_enc_b0", exp_q[0], 8'hC0);
    chk("model_enc_b1", exp_q[1], 8'hC3);
    start_run(2'd0, 7'h60, 7'h01);
    drive(-1);
    wait_done("enc");
    chk("enc_b0", rx_q[0], 8'hC0);
    chk("enc_b1", rx_q[1], 8'hC3);

    // Decrypt mode 1: 0xC0 -> 0x41
    stim.delete();
    stim.push_back(8'hC0);
    for (int i = 1; i < LEN; i++) stim.push_back(8'h00);
    build_expected(2'd1, 7'h60, 7'h01);
    chk("model_dec_b0", exp_q[0], 8'h41);
    start_run(2'd1, 7'h60, 7'h01);
    drive(-1);
    wait_done("dec1a");
    chk("dec1a_b0", rx_q[0], 8'h41);

    // Decrypt mode 1: 0xC1 -> 0xC0 with parity flag
    stim[0] = 8'hC1;
    build_expected(2'd1, 7'h60, 7'h01);
    start_run(2'd1, 7'h60, 7'h01);
    drive(-1);
    wait_done("dec1b");
    chk("dec1b_b0", rx_q[0], 8'hC0);

    // Mode 1 leading-pad strip with a corrupt byte, then mode 3 on the same stream
    set_plain("Hello", 5);
    encrypt_plain(7'h48, 7'h35);
    stim[7] = stim[7] ^ 8'h80;
    build_expected(2'd1, 7'h48, 7'h35);
    chk("model_strip_b0", exp_q[0], 8'h48);
    start_run(2'd1, 7'h48, 7'h35);
    drive(-1);
    wait_done("strip1");
    chk("strip1_b0", rx_q[0], 8'h48);
    build_expected(2'd3, 7'h48, 7'h35);
    start_run(2'd3, 7'h48, 7'h35);
    drive(-1);
    wait_done("mode3");

    // Auto discovery: pattern 0x5C, random seed, 12 pads then "four"
    set_plain("four", 12);
    seed = 7'h01;
    for (int tries = 0; tries < 64; tries++) begin
      seed = 7'($urandom_range(1, 127));
      encrypt_plain(7'h5C, seed);
      build_expected(2'd2, 7'h00, 7'h00);
      if (!m_err && m_idx == 6) break;
    end
    chk("model_disc_idx", m_idx, 6);
    start_run(2'd2, 7'h00, 7'h00);
    drive(-1);
    wait_done("disc");
    chk("disc_found_idx", bus.found_idx, 6);
    chk("disc_err", bus.err, 0);
    chk("disc_f", rx_q[0], 8'h66);
    chk("disc_o", rx_q[1], 8'h6F);
    chk("disc_u", rx_q[2], 8'h75);
    chk("disc_r", rx_q[3], 8'h72);
    chk("disc_pad4", rx_q[4], 8'h20);
    chk("disc_pad63", rx_q[63], 8'h20);

    // Discovery failure: byte 3 bit-flipped
    stim[3] = stim[3] ^ 8'h01;
    build_expected(2'd2, 7'h00, 7'h00);
    start_run(2'd2, 7'h00, 7'h00);
    drive(-1);
    wait_done("disc_fail");
    chk("disc_fail_err", bus.err, 1);
    chk("disc_fail_in_ready", bus.in_ready, 0);

    // Output back-pressure mid-PASS
    fill_random();
    build_expected(2'd0, 7'h72, 7'h11);
    start_run(2'd0, 7'h72, 7'h11);
    fork
      drive(-1);
      stall_at(10);
    join
    wait_done("stall");

    // init at input byte 30, then a fresh complete run
    fill_random();
    build_expected(2'd0, 7'h6A, 7'h5B);
    start_run(2'd0, 7'h6A, 7'h5B);
    drive(30);
    chk("abort_taken", aborted, 1);
    @(negedge clk);
    check_reset_outputs("abort");
    chk("abort_rx_count", rx_q.size(), 30);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_quiet", rx_q.size(), 30);
    fill_random();
    build_expected(2'd0, 7'h6A, 7'h5B);
    start_run(2'd0, 7'h6A, 7'h5B);
    drive(-1);
    wait_done("after_abort");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
